// File: rtl/pkt_head_update_handler_if.sv
// Shared types and port bundles for the head-update handler: metadata layout,
// head-write / metadata handshake bundle, and the heads BRAM write port.
package pkt_head_update_handler_pkg;
  localparam int META_QID_WIDTH = 12;

  typedef struct packed {
    logic [15:0]               size;
    logic [META_QID_WIDTH-1:0] pkt_queue_id;
    logic                      descriptor_only;
    logic                      needs_dsc;
    logic                      drop_data;
    logic                      drop_meta;
  } pkt_meta_with_queues_t;
endpackage

// Both channels use valid/ready: a beat transfers on the clock edge where
// valid & ready are both high; valid and its payload hold until that edge.
interface pkt_head_update_handler_if #(
  parameter int QUEUE_ID_WIDTH = 9,
  parameter int RB_AWIDTH      = 16
);
  import pkt_head_update_handler_pkg::*;

  logic [QUEUE_ID_WIDTH-1:0] in_head_queue_id;
  logic [RB_AWIDTH-1:0]      in_head_value;
  logic                      in_head_valid;
  logic                      in_head_ready;
  pkt_meta_with_queues_t     out_meta_data;
  logic                      out_meta_valid;
  logic                      out_meta_ready;

  modport master (
    output in_head_queue_id, in_head_value, in_head_valid, out_meta_ready,
    input  in_head_ready, out_meta_data, out_meta_valid
  );
  modport slave (
    input  in_head_queue_id, in_head_value, in_head_valid, out_meta_ready,
    output in_head_ready, out_meta_data, out_meta_valid
  );
endinterface

interface bram_interface_io #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_en;
  logic                  rd_en;

  modport owner (output addr, wr_data, wr_en, rd_en, input rd_data);
  modport mem   (input addr, wr_data, wr_en, rd_en, output rd_data);
endinterface

// File: rtl/pkt_head_update_handler.sv
// Applies software head-pointer writes to the queue heads BRAM and emits one
// descriptor_only metadata per queue, coalescing updates while one is queued.
module pkt_head_update_handler
  import pkt_head_update_handler_pkg::*;
#(
  parameter int NB_QUEUES  = 512,
  parameter int FIFO_DEPTH = 16,
  parameter int RB_AWIDTH  = 16,
  localparam int QUEUE_ID_WIDTH = $clog2(NB_QUEUES)
) (
  input  logic                       clk,
  input  logic                       rst,
  pkt_head_update_handler_if.slave   head_if,
  bram_interface_io.owner            q_table_heads,
  input  logic [RB_AWIDTH:0]         rb_size,
  output logic [31:0]                upd_cnt,
  output logic [31:0]                coalesced_cnt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [QUEUE_ID_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          rd_ptr, wr_ptr;
  logic [CNT_W-1:0]          count;
  logic [CNT_W:0]            fill;

  logic                      stage_v;
  logic [QUEUE_ID_WIDTH-1:0] stage_qid;
  logic [RB_AWIDTH-1:0]      stage_head;
  logic [NB_QUEUES-1:0]      pending;

  logic [RB_AWIDTH-1:0]      ring_mask;
  logic [QUEUE_ID_WIDTH-1:0] head_qid;
  logic                      accept, pop, push, head_leaving;

  assign ring_mask = RB_AWIDTH'(rb_size - 1'b1);
  assign head_qid  = fifo_mem[rd_ptr];

  // Staged write is counted as a future FIFO entry so its push never finds the FIFO full.
  assign fill                  = {1'b0, count} + {{CNT_W{1'b0}}, stage_v};
  assign head_if.in_head_ready = !rst && (fill < (CNT_W+1)'(FIFO_DEPTH));
  assign head_if.out_meta_valid = (count != '0);

  assign accept = head_if.in_head_valid && head_if.in_head_ready;
  assign pop    = head_if.out_meta_valid && head_if.out_meta_ready;

  // An entry leaving this cycle cannot absorb the update, so it gets a fresh one.
  assign head_leaving = pop && (head_qid == stage_qid);
  assign push         = stage_v && (!pending[stage_qid] || head_leaving);

  assign q_table_heads.addr    = stage_qid;
  assign q_table_heads.wr_data = stage_head;
  assign q_table_heads.wr_en   = stage_v;
  assign q_table_heads.rd_en   = 1'b0;

  always_comb begin
    head_if.out_meta_data                 = '0;
    head_if.out_meta_data.descriptor_only = 1'b1;
    head_if.out_meta_data.pkt_queue_id    =
      META_QID_WIDTH'(head_qid) << (META_QID_WIDTH - QUEUE_ID_WIDTH);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      stage_qid  <= head_if.in_head_queue_id;
      stage_head <= head_if.in_head_value & ring_mask;
    end
    if (push) fifo_mem[wr_ptr] <= stage_qid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_v       <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      pending       <= '0;
      upd_cnt       <= '0;
      coalesced_cnt <= '0;
    end else begin
      stage_v <= accept;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Clear before set: a same-cycle pop and push of one queue leaves it pending.
      if (pop)  pending[head_qid]  <= 1'b0;
      if (push) pending[stage_qid] <= 1'b1;
      if (stage_v)          upd_cnt       <= upd_cnt + 1'b1;
      if (stage_v && !push) coalesced_cnt <= coalesced_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pkt_head_update_handler.sv
// Directed bench for pkt_head_update_handler: expected BRAM writes and metadata
// are queued at issue time and compared by a monitor as the DUT produces them.
module tb_pkt_head_update_handler;
  import pkt_head_update_handler_pkg::*;

  localparam int Q     = 9;
  localparam int RBW   = 16;
  localparam int DEPTH = 4;
  localparam int MW    = $bits(pkt_meta_with_queues_t);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [RBW:0] rb_size;
  logic [31:0]  upd_cnt, coalesced_cnt;

  pkt_head_update_handler_if #(.QUEUE_ID_WIDTH(Q), .RB_AWIDTH(RBW)) hif ();
  bram_interface_io #(.ADDR_WIDTH(Q), .DATA_WIDTH(RBW)) bram ();
  assign bram.rd_data = '0;

  pkt_head_update_handler #(
    .NB_QUEUES(512), .FIFO_DEPTH(DEPTH), .RB_AWIDTH(RBW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .head_if       (hif),
    .q_table_heads (bram),
    .rb_size       (rb_size),
    .upd_cnt       (upd_cnt),
    .coalesced_cnt (coalesced_cnt)
  );

  // scoreboard
  logic [MW-1:0]    exp_q[$];
  logic [Q+RBW-1:0] bram_q[$];
  int n_checks  = 0;
  int n_pass    = 0;
  int meta_pops = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  function automatic logic [MW-1:0] exp_meta(input int qid);
    pkt_meta_with_queues_t m;
    m                 = '0;
    m.descriptor_only = 1'b1;
    m.pkt_queue_id    = 12'(qid << 3);
    return m;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bram.wr_en) begin
        if (bram_q.size() == 0) fail_now("bram_unexpected_write");
        else check("bram_write", 64'({bram.addr, bram.wr_data}), 64'(bram_q.pop_front()));
      end
      if (hif.out_meta_valid && hif.out_meta_ready) begin
        meta_pops++;
        if (exp_q.size() == 0) fail_now("meta_unexpected");
        else check("meta_out", 64'(hif.out_meta_data), 64'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic write_head(input int qid, input int head, input int exp_wr, input bit exp_push);
    bit taken = 1'b0;
    bram_q.push_back({9'(qid), 16'(exp_wr)});
    if (exp_push) exp_q.push_back(exp_meta(qid));
    hif.in_head_queue_id = 9'(qid);
    hif.in_head_value    = 16'(head);
    hif.in_head_valid    = 1'b1;
    for (int i = 0; i < 100 && !taken; i++) begin
      @(negedge clk);
      taken = hif.in_head_ready;
      @(posedge clk); #1;
    end
    hif.in_head_valid = 1'b0;
    if (!taken) fail_now("head_accept_timeout");
  endtask

  task automatic pop_meta(input int n);
    int target = meta_pops + n;
    hif.out_meta_ready = 1'b1;
    for (int i = 0; i < 100 && meta_pops < target; i++) begin
      @(posedge clk); #1;
    end
    hif.out_meta_ready = 1'b0;
    if (meta_pops < target) fail_now("meta_pop_timeout");
  endtask

  initial begin
    int pops_before;
    rb_size              = 17'd1024;
    hif.in_head_valid    = 1'b0;
    hif.in_head_queue_id = '0;
    hif.in_head_value    = '0;
    hif.out_meta_ready   = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",      64'(hif.in_head_ready), 0);
    check("rst_meta_valid", 64'(hif.out_meta_valid), 0);
    check("rst_wr_en",      64'(bram.wr_en), 0);
    check("rst_rd_en",      64'(bram.rd_en), 0);
    check("rst_upd_cnt",    64'(upd_cnt), 0);
    check("rst_coal_cnt",   64'(coalesced_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(hif.in_head_ready), 1);
    @(posedge clk); #1;

    // single write: BRAM at +1, meta at +2
    write_head(5, 'h40, 'h40, 1'b1);
    @(negedge clk);
    check("t1_meta_not_yet", 64'(hif.out_meta_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_meta_valid", 64'(hif.out_meta_valid), 1);
    pop_meta(1);
    idle(1);
    check("t1_upd_cnt",  64'(upd_cnt), 1);
    check("t1_coal_cnt", 64'(coalesced_cnt), 0);

    // back-to-back writes to q3 coalesce behind one meta
    write_head(3, 1, 1, 1'b1);
    write_head(3, 2, 2, 1'b0);
    write_head(3, 3, 3, 1'b0);
    idle(2);
    check("t2_coal_cnt",   64'(coalesced_cnt), 2);
    check("t2_upd_cnt",    64'(upd_cnt), 4);
    check("t2_meta_valid", 64'(hif.out_meta_valid), 1);

    // pop of q3 in the same cycle as a q3 stage-1 update
    pops_before = meta_pops;
    write_head(3, 4, 4, 1'b1);
    hif.out_meta_ready = 1'b1;
    @(posedge clk); #1;
    hif.out_meta_ready = 1'b0;
    check("t3_pop_seen", 64'(meta_pops), 64'(pops_before + 1));
    write_head(3, 5, 5, 1'b0);
    idle(2);
    check("t3_coal_cnt", 64'(coalesced_cnt), 3);
    check("t3_upd_cnt",  64'(upd_cnt), 6);
    pop_meta(1);
    idle(1);
    check("t3_drained", 64'(hif.out_meta_valid), 0);

    // ring masking
    rb_size = 17'd256;
    write_head(9, 'h1FF, 'hFF, 1'b1);
    pop_meta(1);
    rb_size = 17'd1024;
    idle(1);
    check("t5_upd_cnt", 64'(upd_cnt), 7);

    // fill to depth with downstream stalled, then drain in order
    fork
      begin
        for (int q = 0; q < 6; q++) write_head(q, 'h10 + q, 'h10 + q, 1'b1);
      end
      begin
        idle(8);
        check("t4_ready_low", 64'(hif.in_head_ready), 0);
        check("t4_accepted",  64'(upd_cnt), 11);
        pop_meta(6);
      end
    join
    idle(2);
    check("t4_upd_cnt",  64'(upd_cnt), 13);
    check("t4_coal_cnt", 64'(coalesced_cnt), 3);
    check("t4_drained",  64'(hif.out_meta_valid), 0);

    // reset with entries queued
    write_head(1, 'h21, 'h21, 1'b1);
    write_head(2, 'h22, 'h22, 1'b1);
    write_head(4, 'h24, 'h24, 1'b1);
    idle(2);
    check("t6_meta_queued", 64'(hif.out_meta_valid), 1);
    check("t6_upd_cnt",     64'(upd_cnt), 16);
    check("t6_bram_done",   64'(bram_q.size()), 0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("t6_meta_cleared", 64'(hif.out_meta_valid), 0);
    check("t6_upd_zero",     64'(upd_cnt), 0);
    check("t6_coal_zero",    64'(coalesced_cnt), 0);
    check("t6_ready_in_rst", 64'(hif.in_head_ready), 0);
    check("t6_no_wr",        64'(bram.wr_en), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    write_head(7, 'h11, 'h11, 1'b1);
    idle(1);
    check("t6_post_meta", 64'(hif.out_meta_valid), 1);
    pop_meta(1);
    idle(1);
    check("t6_post_upd",  64'(upd_cnt), 1);
    check("t6_post_coal", 64'(coalesced_cnt), 0);

    check("final_meta_q_empty", 64'(exp_q.size()), 0);
    check("final_bram_q_empty", 64'(bram_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
